rv_prog_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory of the single-cycle RV64IC core. It parses a framed byte stream (magic, word count, little-endian instruction words, XOR checksum) from a UART/host byte source and issues one instruction-memory write per assembled 32-bit word. It holds the core in reset until a frame completes with a valid checksum.

---
 rtl/rv_loader_pkg.sv | 23 ++
 rtl/rv_word_asm.sv | 32 +++
 rtl/rv_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_rv_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package rv_loader_pkg;

    // Frame parser states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // Frame field definitions.
    localparam logic [7:0] LOADER_MAGIC   = 8'hA5;
    localparam int         CNT_W          = 16;
    localparam int         WORD_W         = 32;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         BIDX_W         = 2;

endpackage

// File: rtl/rv_word_asm.sv
// Little-endian byte-to-word assembler: the first byte lands in word[7:0].
module rv_word_asm
    import rv_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic [BIDX_W-1:0] byte_idx,
    output logic              word_valid
);

    // Holds the first three bytes; the fourth is taken straight from byte_in.
    logic [WORD_W-9:0] shift;

    // Shift accepted bytes in from the top and advance the byte index.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift    <= '0;
            byte_idx <= '0;
        end else if (byte_valid) begin
            shift    <= {byte_in, shift[WORD_W-9:8]};
            byte_idx <= byte_idx + BIDX_W'(1);
        end
    end

    assign word       = {byte_in, shift};
    assign word_valid = byte_valid && (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rv_prog_loader.sv
// Framed byte-stream loader for the core's instruction memory; holds the
// core in reset until a frame completes with a matching XOR checksum.
module rv_prog_loader
    import rv_loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              instr_wr_en,
    output logic [ADDR_W-1:0] instr_addr_out,
    output logic [WORD_W-1:0] instr_out,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [63:0]     MAX_WORDS = (64'd1 << (ADDR_W - 2)) - 64'(BASE_ADDR / 4);

    loader_state_t     state, state_next;
    logic [7:0]        cnt_lo;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  word_idx_inc;
    logic [7:0]        xor_acc;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              accept;
    logic              counting;
    logic              tmo_expire;
    logic              entering_cnt_lo;
    logic              asm_clear;
    logic              asm_byte_valid;
    logic [WORD_W-1:0] asm_word;
    logic [BIDX_W-1:0] asm_byte_idx;
    logic              asm_word_valid;

    assign in_ready        = rst_n && (state != ST_WRITE);
    assign accept          = in_valid && in_ready;
    assign counting        = (state == ST_CNT_LO) || (state == ST_CNT_HI) ||
                             (state == ST_DATA)   || (state == ST_CHK);
    // An accepted byte in the expiry cycle wins over the timeout.
    assign tmo_expire      = counting && !accept && (tmo_cnt >= TMO_LAST);
    assign word_idx_inc    = word_idx + CNT_W'(1);
    assign entering_cnt_lo = (state_next == ST_CNT_LO) && (state != ST_CNT_LO);
    assign asm_clear       = (state == ST_CNT_LO);
    assign asm_byte_valid  = accept && (state == ST_DATA);

    rv_word_asm u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_byte_valid),
        .byte_in    (in_data),
        .word       (asm_word),
        .byte_idx   (asm_byte_idx),
        .word_valid (asm_word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode for the frame parser.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && in_data == LOADER_MAGIC) state_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (accept)          state_next = ST_CNT_HI;
                else if (tmo_expire) state_next = ST_ERR;
            end
            ST_CNT_HI: begin
                if (accept) begin
                    if ({48'd0, in_data, cnt_lo} > MAX_WORDS) state_next = ST_ERR;
                    else if ({in_data, cnt_lo} == '0)          state_next = ST_CHK;
                    else                                       state_next = ST_DATA;
                end else if (tmo_expire) begin
                    state_next = ST_ERR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (asm_byte_idx == BIDX_W'(BYTES_PER_WORD - 1)) state_next = ST_WRITE;
                end else if (tmo_expire) begin
                    state_next = ST_ERR;
                end
            end
            ST_WRITE: begin
                state_next = (word_idx_inc == count) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (accept)          state_next = (in_data == xor_acc) ? ST_DONE : ST_ERR;
                else if (tmo_expire) state_next = ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (accept && in_data == LOADER_MAGIC) state_next = ST_CNT_LO;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: count capture, word index, running XOR, idle timer.
    always_ff @(posedge clk) begin
        if (state == ST_CNT_LO && accept) cnt_lo <= in_data;
        if (state == ST_CNT_HI && accept) count  <= {in_data, cnt_lo};

        if (!rst_n || state == ST_CNT_LO) word_idx <= '0;
        else if (state == ST_WRITE)       word_idx <= word_idx_inc;

        if (!rst_n || entering_cnt_lo)
            xor_acc <= '0;
        else if (accept && (state == ST_CNT_LO || state == ST_CNT_HI || state == ST_DATA))
            xor_acc <= xor_acc ^ in_data;

        if (!rst_n || accept)                  tmo_cnt <= '0;
        else if (counting && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Registered write port: strobe, address and word land together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_wr_en    <= 1'b0;
            instr_addr_out <= ADDR_W'(BASE_ADDR);
            instr_out      <= '0;
        end else begin
            instr_wr_en <= 1'b0;
            if (asm_word_valid) begin
                instr_wr_en    <= 1'b1;
                instr_addr_out <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});
                instr_out      <= asm_word;
            end
        end
    end

    // Status and core reset follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (state_next != state) begin
            case (state_next)
                ST_CNT_LO: begin
                    core_rst_n <= 1'b0;
                    load_done  <= 1'b0;
                    load_err   <= 1'b0;
                end
                ST_DONE: begin
                    core_rst_n <= 1'b1;
                    load_done  <= 1'b1;
                end
                ST_ERR: begin
                    core_rst_n <= 1'b0;
                    load_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_prog_loader.sv
// Self-checking bench for rv_prog_loader: frame vector table plus corner sequences.
module tb_rv_prog_loader;
    import rv_loader_pkg::*;

    localparam int ADDR_W = 16;
    localparam int BASE   = 0;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              instr_wr_en;
    logic [ADDR_W-1:0] instr_addr_out;
    logic [31:0]       instr_out;
    logic              core_rst_n;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    rv_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .instr_wr_en    (instr_wr_en),
        .instr_addr_out (instr_addr_out),
        .instr_out      (instr_out),
        .core_rst_n     (core_rst_n),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;
        bit          hdr_only;
        logic        exp_done;
        logic        exp_err;
        logic        exp_core;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] frame_words[4];
    int          tests  = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          last_wr = -100;
    int          gap    = 0;
    int          nwr    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && instr_wr_en) begin
            wr_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", instr_addr_out, instr_out);
            end else begin
                e = exp_q.pop_front();
                if (instr_addr_out !== e.a || instr_out !== e.d) begin
                    fails++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             instr_addr_out, instr_out, e.a, e.d);
                end
            end
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: got %b, required 0", in_ready);
            end
            gap     = cyc - last_wr;
            last_wr = cyc;
            nwr++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte and return right after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL byte_stall: in_ready stuck at %b, required 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send a frame built from frame_words, pushing the writes it should produce.
    task automatic send_frame(input logic [15:0] cnt, input logic [7:0] flip, input bit hdr_only);
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        x = cnt[7:0] ^ cnt[15:8];
        send_byte(LOADER_MAGIC);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (!hdr_only) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w   = frame_words[i % 4];
                e.a = 16'(BASE + 4 * i);
                e.d = w;
                exp_q.push_back(e);
                for (int b = 0; b < 4; b++) begin
                    x = x ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8]);
                end
            end
            send_byte(x ^ flip);
        end
        in_valid = 1'b0;
    endtask

    task automatic good_frame();
        frame_words[0] = 32'h00100513;
        frame_words[1] = 32'h00200593;
        send_frame(16'd2, 8'h00, 1'b0);
        idle(2);
        check("good_done", load_done, 1);
        check("good_core", core_rst_n, 1);
        check("good_q", exp_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int base_nwr;
        vecs[0] = '{16'd2,     32'h00100513, 32'h00200593, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'd2,     32'h00100513, 32'h00200593, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'd2,     32'h00100513, 32'h00200593, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'd0,     32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'd1,     32'hDEADBEEF, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h4001,  32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'd1,     32'h12345678, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("ready_in_reset", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", instr_wr_en, 0);
        check("rst_addr", instr_addr_out, BASE);
        check("rst_data", instr_out, 0);
        check("rst_core", core_rst_n, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", in_ready, 1);
        idle(1);

        // Frame vector table.
        for (int v = 0; v < 7; v++) begin
            frame_words[0] = vecs[v].w0;
            frame_words[1] = vecs[v].w1;
            send_frame(vecs[v].cnt, vecs[v].flip, vecs[v].hdr_only);
            idle(2);
            check($sformatf("vec%0d_done", v), load_done, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v), load_err, vecs[v].exp_err);
            check($sformatf("vec%0d_core", v), core_rst_n, vecs[v].exp_core);
            check($sformatf("vec%0d_q", v), exp_q.size(), 0);
        end

        // Magic after DONE re-asserts core reset and clears status; then stalls into timeout.
        send_byte(LOADER_MAGIC);
        idle(1);
        check("remagic_core", core_rst_n, 0);
        check("remagic_done", load_done, 0);
        check("remagic_err", load_err, 0);
        idle(20);
        check("cntlo_timeout_err", load_err, 1);

        // Idle timeout mid-DATA.
        base_nwr = nwr;
        send_byte(LOADER_MAGIC);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        idle(10);
        check("tmo_not_yet", load_err, 0);
        idle(10);
        check("tmo_err", load_err, 1);
        check("tmo_core", core_rst_n, 0);
        check("tmo_no_write", nwr - base_nwr, 0);
        good_frame();

        // Garbage before magic, continuous stream: one write every 5 cycles.
        base_nwr = nwr;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_ignored", load_done, 1);
        good_frame();
        check("stream_writes", nwr - base_nwr, 2);
        check("stream_gap", gap, 5);

        // Reset in the middle of DATA aborts the frame.
        frame_words[0] = 32'h00100513;
        send_byte(LOADER_MAGIC);
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{16'(BASE), 32'h00100513});
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h93);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_wr_en", instr_wr_en, 0);
        check("midrst_addr", instr_addr_out, BASE);
        check("midrst_data", instr_out, 0);
        check("midrst_core", core_rst_n, 0);
        check("midrst_done", load_done, 0);
        check("midrst_err", load_err, 0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_after", in_ready, 1);
        base_nwr = nwr;
        idle(5);
        check("midrst_no_write", nwr - base_nwr, 0);
        check("midrst_q", exp_q.size(), 0);
        good_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on simulation length.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
